hygro_responder: RTL and testbench

HYGRO_RESPONDER -- requirements
Module: hygro_responder

---
 rtl/hygro_responder_if.sv | 25 ++
 rtl/hygro_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_hygro_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hygro_responder_if.sv
// Sensor-side handshake of the hygro responder: raw samples in,
// conversion status out. The I2C pins stay plain ports on the block.
interface hygro_responder_if;
    logic [13:0] tem_in;
    logic [13:0] hum_in;
    logic        meas_start;
    logic        measuring;
    logic        busy;

    modport slave (
        input  tem_in,
        input  hum_in,
        output meas_start,
        output measuring,
        output busy
    );

    modport master (
        output tem_in,
        output hum_in,
        input  meas_start,
        input  measuring,
        input  busy
    );
endinterface

// File: rtl/hygro_responder.sv
// hygro_responder: I2C target presenting a temperature/humidity sensor.
// Writing pointer 0x00 starts a timed conversion that latches the
// samples at its end. Reads return 4 data bytes, then 0xFF forever.
// Optional build macro HYGRO_RESP_NACK_BUSY_EN: NACK read addresses
// while a conversion is running.
//
// state      | meaning
// -----------+---------------------------------------------------
// S_IDLE     | bus free, waiting for START
// S_ADDR     | shifting in the address byte
// S_ADDR_ACK | driving ACK for a matching address
// S_WR_BYTE  | shifting in a write byte (first one is the pointer)
// S_WR_ACK   | driving ACK for a write byte
// S_RD_BYTE  | shifting out a read byte
// S_RD_ACK   | SDA released, sampling the initiator's ACK/NACK
// S_IGNORE   | not addressed or NACKed, wait for START/STOP
module hygro_responder #(
    parameter logic [6:0]  ADDR        = 7'h40,
    parameter logic [15:0] CONV_CYCLES = 16'd1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SCL,
    inout  wire                SDA,
    hygro_responder_if.slave   sens
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_q, sda_q;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [7:0]  shreg;
    logic [7:0]  tx_sr;
    logic        ack_phase;
    logic        sda_low;
    logic [15:0] timer;
    logic [13:0] tem_l, hum_l;
    logic [7:0]  rd_next;
    logic        addr_ok;

    wire scl_s     = scl_sync[1];
    wire sda_s     = sda_sync[1];
    wire scl_rise  = scl_s & ~scl_q;
    wire scl_fall  = ~scl_s & scl_q;
    wire start_det = scl_s & scl_q & sda_q & ~sda_s;
    wire stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    wire [7:0] rx_byte = {shreg[6:0], sda_s};

    assign SDA = sda_low ? 1'b0 : 1'bz;

`ifdef HYGRO_RESP_NACK_BUSY_EN
    assign addr_ok = (rx_byte[7:1] == ADDR) && !(rx_byte[0] && sens.measuring);
`else
    assign addr_ok = (rx_byte[7:1] == ADDR);
`endif

    // Bring the bus pins into clk; idle level is high so reset gives no edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    // Next read byte selected by the saturating byte counter
    always_comb begin
        rd_next = 8'hFF;
        case (byte_cnt)
            3'd0:    rd_next = tem_l[13:6];
            3'd1:    rd_next = {tem_l[5:0], 2'b00};
            3'd2:    rd_next = hum_l[13:6];
            3'd3:    rd_next = {hum_l[5:0], 2'b00};
            default: rd_next = 8'hFF;
        endcase
    end

    // Protocol FSM plus conversion timer; ACK states use ack_phase to tell
    // the falling edge that opens the ACK bit from the one that closes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            bit_cnt         <= 3'd0;
            byte_cnt        <= 3'd0;
            shreg           <= 8'h00;
            tx_sr           <= 8'hFF;
            ack_phase       <= 1'b0;
            sda_low         <= 1'b0;
            sens.busy       <= 1'b0;
            sens.meas_start <= 1'b0;
            sens.measuring  <= 1'b0;
            timer           <= 16'd0;
            tem_l           <= 14'd0;
            hum_l           <= 14'd0;
        end else begin
            sens.meas_start <= 1'b0;

            if (timer != 16'd0) begin
                timer <= timer - 16'd1;
                if (timer == 16'd1) begin
                    sens.measuring <= 1'b0;
                    tem_l          <= sens.tem_in;
                    hum_l          <= sens.hum_in;
                end
            end

            if (start_det) begin
                state     <= S_ADDR;
                bit_cnt   <= 3'd0;
                byte_cnt  <= 3'd0;
                ack_phase <= 1'b0;
                sda_low   <= 1'b0;
                sens.busy <= 1'b1;
            end else if (stop_det) begin
                state     <= S_IDLE;
                sda_low   <= 1'b0;
                sens.busy <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                state     <= addr_ok ? S_ADDR_ACK : S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_rise) begin
                            ack_phase <= 1'b1;
                        end else if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_low <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                if (shreg[0]) begin
                                    tx_sr    <= rd_next;
                                    sda_low  <= ~rd_next[7];
                                    byte_cnt <= byte_cnt + 3'd1;
                                    state    <= S_RD_BYTE;
                                end else begin
                                    sda_low <= 1'b0;
                                    state   <= S_WR_BYTE;
                                end
                            end
                        end
                    end
                    S_WR_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                state     <= S_WR_ACK;
                                if (byte_cnt == 3'd0 && rx_byte == 8'h00) begin
                                    sens.meas_start <= 1'b1;
                                    sens.measuring  <= 1'b1;
                                    timer           <= CONV_CYCLES;
                                end
                                if (byte_cnt != 3'd4)
                                    byte_cnt <= byte_cnt + 3'd1;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_rise) begin
                            ack_phase <= 1'b1;
                        end else if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_low <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_low   <= 1'b0;
                                state     <= S_WR_BYTE;
                            end
                        end
                    end
                    S_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                state     <= S_RD_ACK;
                            end
                        end else if (scl_fall) begin
                            tx_sr   <= {tx_sr[6:0], 1'b1};
                            sda_low <= ~tx_sr[6];
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            ack_phase <= 1'b1;
                            if (sda_s) begin
                                sda_low <= 1'b0;
                                state   <= S_IGNORE;
                            end
                        end else if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_low <= 1'b0;
                            end else begin
                                ack_phase <= 1'b0;
                                tx_sr     <= rd_next;
                                sda_low   <= ~rd_next[7];
                                if (byte_cnt != 3'd4)
                                    byte_cnt <= byte_cnt + 3'd1;
                                state     <= S_RD_BYTE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hygro_responder.sv
// Bench for hygro_responder: bit-banged I2C initiator, data model of the
// latched sample word, conversion-length and SDA-drive monitors.
module tb_hygro_responder;
    localparam int CONV = 1000;
    localparam int Q    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic scl_m;
    logic sda_m_low;
    wire  sda;

    assign sda = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda);

    hygro_responder_if sens();

    hygro_responder #(.ADDR(7'h40), .CONV_CYCLES(16'd1000)) dut (
        .clk  (clk),
        .rst  (rst),
        .SCL  (scl_m),
        .SDA  (sda),
        .sens (sens)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0, start_cnt = 0, last_start = 0, last_dur = 0, width_err = 0;
    logic meas_prev = 1'b0, ms_prev = 1'b0;
    bit dut_low_seen = 1'b0;

    logic [13:0] m_tem = 14'd0, m_hum = 14'd0;

    // Monitors sampled 2 time units after each falling clk edge
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (sens.meas_start === 1'b1) begin
            start_cnt++;
            last_start = cyc;
        end
        if (sens.meas_start === 1'b1 && ms_prev === 1'b1) width_err++;
        if (meas_prev === 1'b1 && sens.measuring === 1'b0) last_dur = cyc - last_start;
        meas_prev = sens.measuring;
        ms_prev   = sens.meas_start;
        if (!sda_m_low && sda === 1'b0) dut_low_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = {m_tem, 2'b00, m_hum, 2'b00};
        if (i > 3) return 8'hFF;
        return w[31 - 8*i -: 8];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b0; wait_clk(Q);
        scl_m = 1'b1;     wait_clk(Q);
        sda_m_low = 1'b1; wait_clk(Q);
        scl_m = 1'b0;     wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m_low = 1'b1; wait_clk(Q);
        scl_m = 1'b1;     wait_clk(Q);
        sda_m_low = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        sda_m_low = ~b; wait_clk(Q);
        scl_m = 1'b1;   wait_clk(Q);
        r = sda;        wait_clk(Q);
        scl_m = 1'b0;   wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(nack, r);
    endtask

    task automatic wait_conv();
        int n = 0;
        while (sens.measuring === 1'b1 && n < 3000) begin
            wait_clk(1);
            n++;
        end
        check("conv_timeout", {31'd0, sens.measuring}, 32'd0);
        wait_clk(2);
    endtask

    task automatic trigger();
        logic a;
        i2c_start();
        write_byte(8'h80, a); check("trig_addr_ack", {31'd0, a}, 32'd0);
        write_byte(8'h00, a); check("trig_ptr_ack", {31'd0, a}, 32'd0);
        i2c_stop();
    endtask

    task automatic do_convert(input logic [13:0] t, input logic [13:0] h);
        int n0;
        sens.tem_in = t;
        sens.hum_in = h;
        n0 = start_cnt;
        trigger();
        check("meas_start_pulse", start_cnt, n0 + 1);
        check("measuring_high", {31'd0, sens.measuring}, 32'd1);
        wait_conv();
        check("conv_length", last_dur, CONV);
        m_tem = t;
        m_hum = h;
    endtask

    task automatic read_seq(input int n, input logic nack_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1) ? nack_last : 1'b0, d);
            check($sformatf("rd_byte%0d", i), {24'd0, d}, {24'd0, exp_byte(i)});
        end
    endtask

    task automatic do_read(input int n);
        logic a;
        i2c_start();
        write_byte(8'h81, a);
        check("rd_addr_ack", {31'd0, a}, 32'd0);
        read_seq(n, 1'b1);
        i2c_stop();
    endtask

    initial begin
        logic a;
        logic [7:0] d;
        int n0;

        rst = 1'b0; scl_m = 1'b1; sda_m_low = 1'b0;
        sens.tem_in = 14'd0; sens.hum_in = 14'd0;
        wait_clk(5);
        check("rst_sda", {31'd0, sda}, 32'd1);
        check("rst_busy", {31'd0, sens.busy}, 32'd0);
        check("rst_meas_start", {31'd0, sens.meas_start}, 32'd0);
        check("rst_measuring", {31'd0, sens.measuring}, 32'd0);
        rst = 1'b1;
        wait_clk(5);

        // conversion then 4-byte read of the fixed sample
        do_convert(14'h2ABC, 14'h1234);
        do_read(4);

        // non-zero pointer, later zero data byte: no conversion
        n0 = start_cnt;
        i2c_start();
        write_byte(8'h80, a); check("ptr5_addr_ack", {31'd0, a}, 32'd0);
        write_byte(8'h05, a); check("ptr5_ack", {31'd0, a}, 32'd0);
        write_byte(8'h00, a); check("data0_ack", {31'd0, a}, 32'd0);
        i2c_stop();
        check("ptr5_no_trigger", start_cnt, n0);
        check("ptr5_not_measuring", {31'd0, sens.measuring}, 32'd0);

        // foreign address: NACK, SDA untouched, busy until STOP
        dut_low_seen = 1'b0;
        i2c_start();
        write_byte(8'h82, a); check("bad_addr_nack", {31'd0, a}, 32'd1);
        write_byte(8'h00, a); check("ignore_nack", {31'd0, a}, 32'd1);
        check("ignore_busy", {31'd0, sens.busy}, 32'd1);
        i2c_stop();
        wait_clk(5);
        check("ignore_sda_never_low", {31'd0, dut_low_seen}, 32'd0);
        check("stop_busy_low", {31'd0, sens.busy}, 32'd0);
        check("ignore_no_trigger", start_cnt, n0);

        // read while converting
        sens.tem_in = 14'($urandom_range(0, 16383));
        sens.hum_in = 14'($urandom_range(0, 16383));
        trigger();
        i2c_start();
        write_byte(8'h81, a);
`ifdef HYGRO_RESP_NACK_BUSY_EN
        check("busy_rd_nack", {31'd0, a}, 32'd1);
`else
        check("busy_rd_ack", {31'd0, a}, 32'd0);
        read_seq(2, 1'b1);
`endif
        check("busy_still_measuring", {31'd0, sens.measuring}, 32'd1);
        i2c_stop();
        wait_conv();
        m_tem = sens.tem_in;
        m_hum = sens.hum_in;
        do_read(4);

        // retrigger during a conversion restarts the timer
        n0 = start_cnt;
        trigger();
        wait_clk(300);
        check("retrig_measuring", {31'd0, sens.measuring}, 32'd1);
        trigger();
        check("retrig_pulses", start_cnt, n0 + 2);
        wait_conv();
        check("retrig_length", last_dur, CONV);

        // 6-byte read with all ACKed, then repeated START into a new read
        i2c_start();
        write_byte(8'h81, a); check("rd6_addr_ack", {31'd0, a}, 32'd0);
        read_seq(6, 1'b0);
        i2c_start();
        write_byte(8'h81, a); check("rs_addr_ack", {31'd0, a}, 32'd0);
        read_seq(4, 1'b1);
        i2c_stop();

        // randomized conversions and reads
        for (int k = 0; k < 3; k++) begin
            do_convert(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
            do_read(int'($urandom_range(1, 6)));
        end

        // reset pulse during the third read byte
        do_convert(14'h2ABC, 14'h1234);
        i2c_start();
        write_byte(8'h81, a); check("rr_addr_ack", {31'd0, a}, 32'd0);
        read_byte(1'b0, d); check("rr_b0", {24'd0, d}, {24'd0, exp_byte(0)});
        read_byte(1'b0, d); check("rr_b1", {24'd0, d}, {24'd0, exp_byte(1)});
        sda_m_low = 1'b0;
        wait_clk(1);
        check("rr_b2_msb_driven", {31'd0, sda}, 32'd0);
        rst = 1'b0;
        #1;
        check("rr_sda_released", {31'd0, sda}, 32'd1);
        check("rr_busy_low", {31'd0, sens.busy}, 32'd0);
        wait_clk(3);
        check("rr_measuring_low", {31'd0, sens.measuring}, 32'd0);
        rst = 1'b1;
        wait_clk(5);
        m_tem = 14'd0;
        m_hum = 14'd0;
        do_read(4);

        // reset mid-conversion: abort, no late pulse, nothing latched
        sens.tem_in = 14'h3FFF;
        sens.hum_in = 14'h3FFF;
        trigger();
        wait_clk(200);
        n0 = start_cnt;
        rst = 1'b0;
        wait_clk(3);
        check("rc_measuring_low", {31'd0, sens.measuring}, 32'd0);
        rst = 1'b1;
        wait_clk(1200);
        check("rc_no_pulse", start_cnt, n0);
        check("rc_still_idle", {31'd0, sens.measuring}, 32'd0);
        do_read(2);

        check("meas_start_width", width_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
